// File: rtl/life_pkg.sv
// Shared definitions for the Conway life array: sizes, edge modes
// and the neighbour-count survival/birth rule.
package life_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 16;
    localparam int DEF_GEN_W  = 16;

    typedef enum logic {
        MODE_EXTERNAL = 1'b0,
        MODE_WRAP     = 1'b1
    } wrap_mode_e;

    function automatic logic [3:0] count_live(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic life_rule(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_cell.sv
// One life cell: state register with row load, generation step and
// the combinational next state exposed for the stability compare.
module life_cell
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       load_val,
    input  logic       step,
    input  logic [7:0] nbrs,
    output logic       state,
    output logic       nxt_state
);

    assign nxt_state = life_rule(state, count_live(nbrs));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= 1'b0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= nxt_state;
        end
    end

endmodule

// File: rtl/life_array_param.sv
// WIDTH x HEIGHT life grid with row load/read, tileable edges,
// optional torus wrap, previous-generation readout and status flags.
module life_array_param
    import life_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int SEL_W  = $clog2(HEIGHT),
    parameter int GEN_W  = DEF_GEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  vali,
    input  logic [SEL_W-1:0]  vali_selector,
    input  logic [SEL_W-1:0]  valo_selector,
    input  logic              write_enb,
    input  logic              step,
    input  logic              wrap,
    output logic [WIDTH-1:0]  valo,
    output logic [WIDTH-1:0]  valo_prev,
    input  logic [WIDTH-1:0]  ni,
    input  logic [WIDTH-1:0]  si,
    input  logic [HEIGHT-1:0] wi,
    input  logic [HEIGHT-1:0] ei,
    input  logic              nwi,
    input  logic              nei,
    input  logic              sei,
    input  logic              swi,
    output logic [WIDTH-1:0]  no,
    output logic [WIDTH-1:0]  so,
    output logic [HEIGHT-1:0] wo,
    output logic [HEIGHT-1:0] eo,
    output logic              nwo,
    output logic              neo,
    output logic              seo,
    output logic              swo,
    output logic [GEN_W-1:0]  gen_count,
    output logic              stable,
    output logic              extinct
);

    localparam int N = WIDTH * HEIGHT;

    logic [N-1:0]      cur;
    logic [N-1:0]      nxt;
    logic [N-1:0]      prev;
    logic [HEIGHT-1:0] row_load;
    logic              do_step;
    logic              torus;

    // Grid padded by one cell on every side; bit 0 is the west pad.
    logic [WIDTH+1:0]  ring [HEIGHT+2];

    assign do_step = step & ~write_enb;
    assign torus   = (wrap == MODE_WRAP);

    always_comb begin
        for (int r = 0; r < HEIGHT; r++) begin
            ring[r+1] = {torus ? cur[r*WIDTH] : ei[r],
                         cur[r*WIDTH +: WIDTH],
                         torus ? cur[r*WIDTH+WIDTH-1] : wi[r]};
        end
        ring[0] = torus ? {cur[(HEIGHT-1)*WIDTH],
                           cur[(HEIGHT-1)*WIDTH +: WIDTH],
                           cur[N-1]}
                        : {nei, ni, nwi};
        ring[HEIGHT+1] = torus ? {cur[0], cur[0 +: WIDTH], cur[WIDTH-1]}
                               : {sei, si, swi};
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        assign row_load[r] = write_enb && (vali_selector == SEL_W'(r));
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [7:0] nbrs;
            assign nbrs = {ring[r][c+2:c],
                           ring[r+1][c+2],
                           ring[r+1][c],
                           ring[r+2][c+2:c]};
            life_cell u_cell (
                .clk       (clk),
                .reset     (reset),
                .load      (row_load[r]),
                .load_val  (vali[c]),
                .step      (do_step),
                .nbrs      (nbrs),
                .state     (cur[r*WIDTH+c]),
                .nxt_state (nxt[r*WIDTH+c])
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
        end else if (do_step) begin
            prev      <= cur;
            gen_count <= gen_count + GEN_W'(1);
            stable    <= (nxt == cur);
        end
    end

    // Out-of-range selectors match no row and read as zero.
    always_comb begin
        valo      = '0;
        valo_prev = '0;
        for (int r = 0; r < HEIGHT; r++) begin
            if (valo_selector == SEL_W'(r)) begin
                valo      = cur[r*WIDTH +: WIDTH];
                valo_prev = prev[r*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < HEIGHT; r++) begin
            wo[r] = cur[r*WIDTH];
            eo[r] = cur[r*WIDTH+WIDTH-1];
        end
    end

    assign no      = cur[0 +: WIDTH];
    assign so      = cur[(HEIGHT-1)*WIDTH +: WIDTH];
    assign nwo     = cur[0];
    assign neo     = cur[WIDTH-1];
    assign seo     = cur[N-1];
    assign swo     = cur[(HEIGHT-1)*WIDTH];
    assign extinct = ~|cur;

endmodule
